// File: rtl/tdc_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tdc_readout_arbiter
// Purpose  : Round-robin readout scheduler sharing one event output stream
//            between N_SRC TDC modules. For each event it grants one pending
//            source, captures its timestamp/tot/channel, clears it through
//            the TDC clear handshake and offers the event on a valid/ready
//            output port.
// Ports    : clk, reset_n (async, active-low), enable (permits new grants)
//            src_has_event / src_timestamp / src_tot / src_chan  <- TDC buses
//            src_clear                                           -> TDC buses
//            out_valid, out_ready, out_timestamp, out_tot,
//            out_chan, out_src                                   output port
//            busy        high whenever the FSM is not IDLE
//            evt_count   accepted-event counter (only with TDC_ARB_EVTCNT_EN)
// Options  : TDC_ARB_EVTCNT_EN - adds the 32-bit evt_count port and counter.
// Params   : N_SRC (2..16), SRC_W (derived, do not override)
// Revision : 1.0 - initial release
// ============================================================================
module tdc_readout_arbiter #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [N_SRC-1:0]     src_has_event,
  input  logic [32*N_SRC-1:0]  src_timestamp,
  input  logic [32*N_SRC-1:0]  src_tot,
  input  logic [4*N_SRC-1:0]   src_chan,
  output logic [N_SRC-1:0]     src_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_timestamp,
  output logic [31:0]          out_tot,
  output logic [3:0]           out_chan,
  output logic [SRC_W-1:0]     out_src,
  output logic                 busy
`ifdef TDC_ARB_EVTCNT_EN
  ,
  output logic [31:0]          evt_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [SRC_W-1:0]    last_grant;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_found;
  logic [N_SRC-1:0]    grant_onehot;
  logic [31:0]         sel_ts;
  logic [31:0]         sel_tot;
  logic [3:0]          sel_chan;

  logic                do_grant;
  logic                do_release;
  logic                do_accept;

  // Round-robin search: first pending source starting at last_grant+1,
  // wrapping around. last_grant itself is examined last.
  always_comb begin
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    cand         = 0;
    cand_idx     = '0;
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand     = (int'(last_grant) + k) % N_SRC;
      cand_idx = cand[SRC_W-1:0];
      if (!grant_found && src_has_event[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    grant_onehot[grant_idx] = grant_found;
  end

  // Data mux for the candidate source, captured only on the grant edge.
  always_comb begin
    sel_ts   = '0;
    sel_tot  = '0;
    sel_chan = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_ts   = src_timestamp[32*i +: 32];
        sel_tot  = src_tot[32*i +: 32];
        sel_chan = src_chan[4*i +: 4];
      end
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_nx   = state;
    do_grant   = 1'b0;
    do_release = 1'b0;
    do_accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && grant_found) begin
          do_grant = 1'b1;
          state_nx = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // The granted source acknowledges clear by dropping hasEvent.
        if (!src_has_event[out_src]) begin
          do_release = 1'b1;
          state_nx   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_valid && out_ready) begin
          do_accept = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Registered outputs. Captured data is loaded only on the grant edge, so
  // later changes on the source bus never reach the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_clear     <= '0;
      out_valid     <= 1'b0;
      out_timestamp <= '0;
      out_tot       <= '0;
      out_chan      <= '0;
      out_src       <= '0;
      busy          <= 1'b0;
      // Source 0 gets first priority after reset.
      last_grant    <= SRC_W'(N_SRC - 1);
    end else begin
      busy <= (state_nx != ST_IDLE);
      if (do_grant) begin
        out_timestamp <= sel_ts;
        out_tot       <= sel_tot;
        out_chan      <= sel_chan;
        out_src       <= grant_idx;
        src_clear     <= grant_onehot;
      end
      if (do_release) begin
        src_clear <= '0;
        out_valid <= 1'b1;
      end
      if (do_accept) begin
        out_valid  <= 1'b0;
        last_grant <= out_src;
      end
    end
  end

`ifdef TDC_ARB_EVTCNT_EN
  logic [31:0] evt_cnt;

  // Free-running wrap from 0xFFFFFFFF to 0 is intended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       evt_cnt <= '0;
    else if (do_accept) evt_cnt <= evt_cnt + 32'd1;
  end

  assign evt_count = evt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_readout_arbiter
// Purpose  : Directed self-checking bench for tdc_readout_arbiter with a
//            small TDC source model (drops hasEvent one cycle after clear
//            rises, optional hold and automatic re-arm per source).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_readout_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            out_ready = 1'b1;

  // Source model state: want = source has an event to offer, served = the
  // arbiter has cleared it, hold = ignore clear, rearm = re-raise after clear.
  logic [N-1:0]    want   = '0;
  logic [N-1:0]    served = '0;
  logic [N-1:0]    seen   = '0;
  logic [N-1:0]    hold   = '0;
  logic [N-1:0]    rearm  = '0;

  logic [N-1:0]    src_has_event;
  logic [32*N-1:0] src_timestamp = '0;
  logic [32*N-1:0] src_tot = '0;
  logic [4*N-1:0]  src_chan = '0;
  logic [N-1:0]    src_clear;
  logic            out_valid;
  logic [31:0]     out_timestamp;
  logic [31:0]     out_tot;
  logic [3:0]      out_chan;
  logic [1:0]      out_src;
  logic            busy;
`ifdef TDC_ARB_EVTCNT_EN
  logic [31:0]     evt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign src_has_event = want & ~served;

  tdc_readout_arbiter #(.N_SRC(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .src_has_event (src_has_event),
    .src_timestamp (src_timestamp),
    .src_tot       (src_tot),
    .src_chan      (src_chan),
    .src_clear     (src_clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_timestamp (out_timestamp),
    .out_tot       (out_tot),
    .out_chan      (out_chan),
    .out_src       (out_src),
    .busy          (busy)
`ifdef TDC_ARB_EVTCNT_EN
    ,
    .evt_count     (evt_count)
`endif
  );

  always #5 clk = ~clk;

  // TDC model: a source sees clear at the first edge after it rises and
  // drops hasEvent shortly after the following edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (src_clear[i] && seen[i] && !hold[i])
        served[i] = 1'b1;
      else if (!src_clear[i] && served[i] && (rearm[i] || !want[i]))
        served[i] = 1'b0;
      seen[i] = src_clear[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_clear_nz();
    int k = 0;
    while (src_clear == '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_clear_zero();
    int k = 0;
    while (src_clear != '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic do_reset();
    want    = '0;
    hold    = '0;
    rearm   = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          exp_order [6];
    logic [3:0]  one;
    exp_order = '{0, 1, 3, 0, 1, 3};

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_clear", src_clear, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_ts",    out_timestamp, 0);
    check("rst_tot",   out_tot, 0);
    check("rst_chan",  out_chan, 0);
    check("rst_src",   out_src, 0);
`ifdef TDC_ARB_EVTCNT_EN
    check("rst_cnt",   evt_count, 0);
`endif
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);

    // ---------------- single event on source 2 ----------------
    src_timestamp[64 +: 32] = 32'h0000_1234;
    src_tot[64 +: 32]       = 32'h0000_0050;
    src_chan[8 +: 4]        = 4'd7;
    want[2]                 = 1'b1;
    @(negedge clk);
    check("t1_clear_c1", src_clear, 4'b0100);
    check("t1_busy",     busy, 1);
    check("t1_valid_lo", out_valid, 0);
    @(negedge clk);
    check("t1_clear_c2", src_clear, 4'b0100);
    @(negedge clk);
    check("t1_clear_off", src_clear, 0);
    check("t1_valid",     out_valid, 1);
    check("t1_ts",        out_timestamp, 32'h1234);
    check("t1_tot",       out_tot, 32'h50);
    check("t1_chan",      out_chan, 7);
    check("t1_src",       out_src, 2);
    @(negedge clk);
    check("t1_valid_1cyc", out_valid, 0);
    check("t1_idle",       busy, 0);
`ifdef TDC_ARB_EVTCNT_EN
    check("t1_cnt", evt_count, 1);
`endif
    want[2] = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- round-robin fairness ----------------
    do_reset();
    rearm = 4'b1011;
    want  = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      wait_clear_nz();
      one = 4'b0001 << exp_order[i];
      check($sformatf("rr_grant%0d", i), src_clear, one);
      if (i < 5) wait_clear_zero();
    end
    want  = '0;
    rearm = '0;
    wait_idle("rr_drain");
    repeat (2) @(negedge clk);

    // ---------------- backpressure ----------------
    // last_grant = 3 here, so source 1 is the only pending one.
    out_ready               = 1'b0;
    src_timestamp[32 +: 32] = 32'hAAAA_0001;
    src_tot[32 +: 32]       = 32'h0000_0011;
    src_chan[4 +: 4]        = 4'd3;
    want[1]                 = 1'b1;
    wait_valid("bp_valid");
    src_timestamp[32 +: 32] = 32'hDEAD_BEEF;
    src_tot[32 +: 32]       = 32'h0000_0099;
    want[0]                 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold_ts%0d", i), out_timestamp, 32'hAAAA_0001);
      check($sformatf("bp_no_grant%0d", i), src_clear, 0);
    end
    check("bp_tot", out_tot, 32'h11);
    check("bp_src", out_src, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", out_valid, 0);
    check("bp_accept_clear", src_clear, 0);
    @(negedge clk);
    check("bp_next_grant", src_clear, 4'b0001);
    want = '0;
    wait_idle("bp_drain");
    repeat (2) @(negedge clk);

    // ---------------- enable gating ----------------
    enable  = 1'b0;
    want[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("en_busy",  busy, 0);
    check("en_clear", src_clear, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_grant", src_clear, 4'b0010);
    check("en_busy_hi", busy, 1);
    want = '0;
    wait_idle("en_drain");
    repeat (2) @(negedge clk);

    // ---------------- reset mid-CLEAR ----------------
    // last_grant = 1, so source 3 wins over source 0 here.
    hold[3] = 1'b1;
    want    = 4'b1000;
    wait_clear_nz();
    check("rc_grant3", src_clear, 4'b1000);
    want[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rc_stuck", src_clear, 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    check("rc_clear_async", src_clear, 0);
    check("rc_valid_async", out_valid, 0);
    check("rc_busy_async",  busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hold[3] = 1'b0;
    @(negedge clk);
    check("rc_regrant0", src_clear, 4'b0001);
    wait_clear_zero();
    wait_clear_nz();
    check("rc_regrant3", src_clear, 4'b1000);
    want = '0;
    wait_idle("rc_drain");
    repeat (2) @(negedge clk);

`ifdef TDC_ARB_EVTCNT_EN
    // ---------------- counter wrap ----------------
    dut.evt_cnt = 32'hFFFF_FFFF;
    want[2] = 1'b1;
    wait_valid("wrap_valid");
    @(negedge clk);
    check("wrap_cnt", evt_count, 0);
    want = '0;
    wait_idle("wrap_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
